// File: rtl/ila_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ila_mon_pkg
// Purpose : Shared definitions for the ILA-vs-RTL pipeline tracking monitor.
//           - err_code_e    : error classification used by wrapper assertions
//           - DEF_MAX_CYCLES: default saturation / timeout bound of cycle_cnt
//           - stall_idx()   : flat bit index of pipe p, stage s in stall/occ
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ila_mon_pkg;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LOST    = 2'd1,
    ERR_DUP     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  // Default value cycle_cnt saturates at; it doubles as the timeout bound.
  localparam int unsigned DEF_MAX_CYCLES = 6;

  // Stage s of pipe p lives at bit p*num_stages+s of the flattened vectors.
  function automatic int unsigned stall_idx(input int unsigned p,
                                            input int unsigned s,
                                            input int unsigned num_stages);
    return p * num_stages + s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ila_stage_chain.sv
`default_nettype none
// ============================================================================
// Module  : ila_stage_chain
// Purpose : Follows the tracked token through one stall-able pipeline.
//           S1 occupancy is combinational (start && enter); S2..Sn are
//           registered and advance whenever their own stage is not stalled.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           start          - one-cycle tracking start pulse
//           enter          - S1 acceptance of this pipe
//           stall[s]       - stall of stage s (s=0 is S1)
//           cycle_cnt      - running cycle count, sampled into latency
//           occ[s]         - token occupancy per stage
//           commit         - one-cycle pulse when the token leaves the last stage
//           committed      - sticky commit
//           latency        - cycle_cnt captured together with commit
//           lost_err       - sticky: token advanced into a holding stage
//           dup_err        - sticky: commit seen while already committed
// Revision: 1.0 - initial release
// ============================================================================
module ila_stage_chain
  import ila_mon_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  enter,
  input  logic [NUM_STAGES-1:0] stall,
  input  logic [CNT_W-1:0]      cycle_cnt,
  output logic [NUM_STAGES-1:0] occ,
  output logic                  commit,
  output logic                  committed,
  output logic [CNT_W-1:0]      latency,
  output logic                  lost_err,
  output logic                  dup_err
);

  logic [NUM_STAGES-1:1] occ_q;
  logic [NUM_STAGES-1:0] nxt;
  logic                  lost_now;

  always_comb begin
    occ = {occ_q, start & enter};
    nxt = occ & ~stall;
    // A token leaving stage s-1 while stage s holds has nowhere to go.
    lost_now = |(nxt[NUM_STAGES-2:0] & stall[NUM_STAGES-1:1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q     <= '0;
      commit    <= 1'b0;
      committed <= 1'b0;
      latency   <= '0;
      lost_err  <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      for (int s = 1; s < NUM_STAGES; s++) begin
        if (!stall[s]) occ_q[s] <= nxt[s-1];
      end
      commit <= nxt[NUM_STAGES-1];
      // Sampled on the same edge that registers commit.
      if (nxt[NUM_STAGES-1]) latency <= cycle_cnt;
      if (commit)             committed <= 1'b1;
      if (lost_now)           lost_err  <= 1'b1;
      if (commit && committed) dup_err  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ila_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module  : ila_pipe_tracker
// Purpose : Refinement-check monitor: tracks one issued instruction token
//           through NUM_PIPES pipelines of NUM_STAGES stages (NUM_STAGES >= 2),
//           producing start/end handshake flags, a saturating cycle counter,
//           per-pipe commit/latency and token-loss/double-commit/timeout errors.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           issue      - request to start tracking
//           enter[p]   - S1 acceptance of pipe p
//           stall      - stall of pipe p, stage s at bit p*NUM_STAGES+s
//           start      - one-cycle start pulse; started - sticky active flag
//           cycle_cnt  - cycles since start, saturating at MAX_CYCLES
//           iend       - first-end pulse; ended/ended2 - sticky end flags
//           occ        - token occupancy per stage (same layout as stall)
//           commit / committed / latency - per-pipe commit information
//           lost_err, dup_err, timeout   - sticky error flags
// Revision: 1.0 - initial release
// ============================================================================
module ila_pipe_tracker
  import ila_mon_pkg::*;
#(
  parameter int NUM_PIPES  = 2,
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 4,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int END_CYCLE  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue,
  input  logic [NUM_PIPES-1:0]            enter,
  input  logic [NUM_PIPES*NUM_STAGES-1:0] stall,
  output logic                            start,
  output logic                            started,
  output logic [CNT_W-1:0]                cycle_cnt,
  output logic                            iend,
  output logic                            ended,
  output logic                            ended2,
  output logic [NUM_PIPES*NUM_STAGES-1:0] occ,
  output logic [NUM_PIPES-1:0]            commit,
  output logic [NUM_PIPES-1:0]            committed,
  output logic [NUM_PIPES*CNT_W-1:0]      latency,
  output logic                            lost_err,
  output logic                            dup_err,
  output logic                            timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(END_CYCLE);

  logic [NUM_PIPES-1:0] entered;   // pipes that accepted the token at start
  logic [NUM_PIPES-1:0] pipe_lost;
  logic [NUM_PIPES-1:0] pipe_dup;
  logic                 edcond;
  logic                 timeout_now;

  always_comb begin
    edcond      = started && (cycle_cnt == CNT_END);
    iend        = edcond && !ended;
    // Only pipes that actually received the token can be late.
    timeout_now = started && (cycle_cnt == CNT_MAX) && |(entered & ~committed);
    lost_err    = |pipe_lost;
    dup_err     = |pipe_dup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start     <= 1'b0;
      started   <= 1'b0;
      cycle_cnt <= '0;
      ended     <= 1'b0;
      ended2    <= 1'b0;
      entered   <= '0;
      timeout   <= 1'b0;
    end else begin
      // Single pulse per reset: issue after the first start is ignored.
      start <= issue && !start && !started;
      if (start) started <= 1'b1;
      if ((start || started) && (cycle_cnt < CNT_MAX)) cycle_cnt <= cycle_cnt + 1'b1;
      if (iend) ended <= 1'b1;
      if (ended && edcond && !ended2) ended2 <= 1'b1;
      if (start) entered <= entered | enter;
      if (timeout_now) timeout <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
    ila_stage_chain #(
      .NUM_STAGES (NUM_STAGES),
      .CNT_W      (CNT_W)
    ) u_chain (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .enter     (enter[p]),
      .stall     (stall[stall_idx(p, 0, NUM_STAGES) +: NUM_STAGES]),
      .cycle_cnt (cycle_cnt),
      .occ       (occ[stall_idx(p, 0, NUM_STAGES) +: NUM_STAGES]),
      .commit    (commit[p]),
      .committed (committed[p]),
      .latency   (latency[p*CNT_W +: CNT_W]),
      .lost_err  (pipe_lost[p]),
      .dup_err   (pipe_dup[p])
    );
  end

endmodule
`default_nettype wire
